// File: rtl/io_pause_controller_pkg.sv
// Shared types and constants for the I/O pause controller.
// Contents: io_state_e FSM state enum, IO_DATA_W data width, DIR_IN/DIR_OUT direction codes.
package io_ctrl_pkg;

    localparam int unsigned IO_DATA_W = 8;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        RESUME
    } io_state_e;

endpackage

// File: rtl/io_pause_controller_if.sv
// Bundle between the cycle generator / operator panel and the I/O pause controller.
// master: drives phase_b, io_req, io_dir, switch_in, button; receives the status outputs.
// slave : the controller; drives hold, in_data, in_valid, out_ack, waiting
//         (and timeout when IO_TIMEOUT_EN is defined).
interface io_pause_controller_if;
    import io_ctrl_pkg::*;

    logic                 phase_b;
    logic                 io_req;
    logic                 io_dir;
    logic [IO_DATA_W-1:0] switch_in;
    logic                 button;
    logic                 hold;
    logic [IO_DATA_W-1:0] in_data;
    logic                 in_valid;
    logic                 out_ack;
    logic                 waiting;
`ifdef IO_TIMEOUT_EN
    logic                 timeout;

    modport master (
        output phase_b, io_req, io_dir, switch_in, button,
        input  hold, in_data, in_valid, out_ack, waiting, timeout
    );
    modport slave (
        input  phase_b, io_req, io_dir, switch_in, button,
        output hold, in_data, in_valid, out_ack, waiting, timeout
    );
`else
    modport master (
        output phase_b, io_req, io_dir, switch_in, button,
        input  hold, in_data, in_valid, out_ack, waiting
    );
    modport slave (
        input  phase_b, io_req, io_dir, switch_in, button,
        output hold, in_data, in_valid, out_ack, waiting
    );
`endif

endinterface

// File: rtl/io_pause_controller_debouncer.sv
// Operator button conditioning: 2-flop synchronizer followed by a debouncer.
// Ports: clk, reset (async, active-high), button (raw async input),
//        deb_btn (debounced level), press_pulse / release_pulse (single-cycle, combinational,
//        asserted in the cycle whose closing edge flips deb_btn).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic deb_btn,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_a_q, sync_b_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             flip;

    // cnt_q holds how many consecutive samples already disagreed with deb_q;
    // the DEBOUNCE_CYCLES-th disagreeing sample flips the level.
    assign differ = (sync_b_q != deb_q);
    assign flip   = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= 1'b0;
            sync_b_q <= 1'b0;
            deb_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_a_q <= button;
            sync_b_q <= sync_a_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (flip) begin
                cnt_q <= '0;
                deb_q <= sync_b_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign deb_btn       = deb_q;
    assign press_pulse   = flip &  sync_b_q;
    assign release_pulse = flip & ~sync_b_q;

endmodule

// File: rtl/io_pause_controller.sv
// I/O pause controller: freezes the four-phase cycle generator in phase b while an IN/OUT
// instruction waits for an operator button press-and-release, capturing the switch bank for
// input instructions.
// Ports: clk, reset (async, active-high), bus (io_pause_controller_if.slave).
// Optional feature macro: IO_TIMEOUT_EN -- bounds WAIT_PRESS to TIMEOUT_CYCLES and drives
// bus.timeout; without it WAIT_PRESS waits indefinitely.
module io_pause_controller
    import io_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input logic                 clk,
    input logic                 reset,
    io_pause_controller_if.slave bus
);

    io_state_e            state_q, state_d;
    logic                 dir_q, dir_d;
    logic                 served_q, served_d;
    logic [IO_DATA_W-1:0] in_data_q, in_data_d;
    logic                 in_valid_q, in_valid_d;
    logic                 waiting_q;
    logic                 out_ack;
    logic                 accept;
    logic                 press_pulse, release_pulse;
    logic                 deb_btn;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk           (clk),
        .reset         (reset),
        .button        (bus.button),
        .deb_btn       (deb_btn),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    // served blocks a second acceptance while the same phase-b occurrence persists.
    assign accept = (state_q == IDLE) & bus.phase_b & bus.io_req & ~served_q;

`ifdef IO_TIMEOUT_EN
    logic [19:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_hit;

    assign tmo_hit = (state_q == WAIT_PRESS) && (tmo_cnt_q == 20'(TIMEOUT_CYCLES - 1));
`else
    logic [19:0] unused_timeout_cfg;
    logic        unused_deb_btn;

    assign unused_timeout_cfg = 20'(TIMEOUT_CYCLES);
    assign unused_deb_btn     = deb_btn;
`endif

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        in_data_d  = in_data_q;
        in_valid_d = 1'b0;
        out_ack    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_PRESS;
                    dir_d   = bus.io_dir;
                end
            end
            WAIT_PRESS: begin
                // Press wins over a coincident timeout.
                if (press_pulse) begin
                    state_d = WAIT_RELEASE;
                    if (dir_q == DIR_IN) begin
                        in_data_d  = bus.switch_in;
                        in_valid_d = 1'b1;
                    end
`ifdef IO_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = RESUME;
                    if (dir_q == DIR_IN) begin
                        in_data_d  = '0;
                        in_valid_d = 1'b1;
                    end
`endif
                end
            end
            WAIT_RELEASE: begin
                if (release_pulse) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                state_d = IDLE;
                out_ack = (dir_q == DIR_OUT);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        served_d = served_q | accept;
        if (!bus.phase_b) begin
            served_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_IN;
            served_q   <= 1'b0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            waiting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            served_q   <= served_d;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            waiting_q  <= (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
        end
    end

`ifdef IO_TIMEOUT_EN
    // Counts cycles spent in WAIT_PRESS; zero on any other state or on leaving.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == WAIT_PRESS) && (state_d == WAIT_PRESS)) begin
            tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign bus.timeout = tmo_hit & ~press_pulse;
`endif

    // Combinational so the generator freezes on the same edge the request appears.
    assign bus.hold     = (state_q != IDLE) | accept;
    assign bus.in_data  = in_data_q;
    assign bus.in_valid = in_valid_q;
    assign bus.out_ack  = out_ack;
    assign bus.waiting  = waiting_q;

endmodule

// File: tb/tb_io_pause_controller.sv
// Randomized self-checking bench for io_pause_controller with a behavioural reference model.
module tb_io_pause_controller;
    import io_ctrl_pkg::*;

    localparam int unsigned D   = 16;
    localparam int unsigned TMO = 100;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    io_pause_controller_if bus();

    io_pause_controller #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Button history gives the synchronized sample (two edges late); the debounced level
    // flips when the last D synchronized samples all disagree with it.
    bit         hist[$];
    bit         win[$];
    bit         deb_m;
    int         mode_m;      // 0 idle, 1 await press, 2 await release, 3 resume
    bit         dir_m;
    bit         served_m;
    bit         iv_m;
    logic [7:0] data_m;
    int         wait_n;
    int         iv_cnt  = 0;
    int         ack_cnt = 0;
    int         tmo_cnt = 0;

    task automatic model_clear();
        hist     = '{1'b0, 1'b0};
        win.delete();
        deb_m    = 1'b0;
        mode_m   = 0;
        dir_m    = 1'b0;
        served_m = 1'b0;
        iv_m     = 1'b0;
        data_m   = 8'h00;
        wait_n   = 0;
    endtask

    function automatic bit peek_press();
        if (deb_m || win.size() < D - 1) return 1'b0;
        for (int i = win.size() - (D - 1); i < win.size(); i++)
            if (!win[i]) return 1'b0;
        return hist[hist.size() - 2];
    endfunction

    task automatic model_step();
        bit synced, prs_ev, rel_ev, all_diff;
        synced = hist[hist.size() - 2];
        hist.push_back(bus.button);
        if (hist.size() > 2) void'(hist.pop_front());
        win.push_back(synced);
        if (win.size() > D) void'(win.pop_front());
        prs_ev = 1'b0;
        rel_ev = 1'b0;
        if (win.size() == D) begin
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == deb_m) all_diff = 1'b0;
            if (all_diff) begin
                deb_m  = !deb_m;
                prs_ev = deb_m;
                rel_ev = !deb_m;
            end
        end
        iv_m = 1'b0;
        case (mode_m)
            0: if (bus.phase_b && bus.io_req && !served_m) begin
                mode_m   = 1;
                dir_m    = bus.io_dir;
                served_m = 1'b1;
                wait_n   = 0;
            end
            1: begin
                if (prs_ev) begin
                    mode_m = 2;
                    if (!dir_m) begin
                        data_m = bus.switch_in;
                        iv_m   = 1'b1;
                    end
                end
`ifdef IO_TIMEOUT_EN
                else if (wait_n == TMO - 1) begin
                    mode_m = 3;
                    if (!dir_m) begin
                        data_m = 8'h00;
                        iv_m   = 1'b1;
                    end
                end else wait_n++;
`endif
            end
            2: if (rel_ev) mode_m = 3;
            default: mode_m = 0;
        endcase
        if (!bus.phase_b) served_m = 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else model_step();
    end

    always @(negedge clk) begin
        if (bus.in_valid === 1'b1) iv_cnt++;
        if (bus.out_ack === 1'b1) ack_cnt++;
`ifdef IO_TIMEOUT_EN
        if (bus.timeout === 1'b1) tmo_cnt++;
`endif
        if (!reset) begin
            check("hold", bus.hold,
                  (mode_m != 0) || (bus.phase_b && bus.io_req && !served_m));
            check("waiting", bus.waiting, (mode_m == 1) || (mode_m == 2));
            check("in_valid", bus.in_valid, iv_m);
            check("out_ack", bus.out_ack, (mode_m == 3) && dir_m);
            check("in_data", bus.in_data, data_m);
`ifdef IO_TIMEOUT_EN
            check("timeout", bus.timeout,
                  (mode_m == 1) && (wait_n == TMO - 1) && !peek_press());
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_io(bit dir, logic [7:0] sw, bit bounce, bit pre);
        int iv0, ack0, guard;
        iv0  = iv_cnt;
        ack0 = ack_cnt;
        if (pre) begin
            bus.button = 1'b1;
            cyc(D + 4);
        end
        bus.phase_b   = 1'b1;
        bus.io_req    = 1'b1;
        bus.io_dir    = dir;
        bus.switch_in = sw;
        cyc($urandom_range(1, 4));
        if (pre) begin
            // held-over press must not count; release it first
            bus.button = 1'b0;
            cyc(D + 4);
        end
        if (bounce) begin
            bus.button = 1'b0;
            repeat (13) begin
                bus.button = ~bus.button;
                cyc(3);
            end
            bus.button = 1'b1;
            cyc(D + 2 + $urandom_range(0, 6));
        end else begin
            bus.button = 1'b1;
            cyc(D + 3 + $urandom_range(0, 8));
        end
        if ($urandom_range(0, 1) == 1) begin
            bus.button = 1'b0;
            cyc(2);
            bus.button = 1'b1;
            cyc(2);
        end
        bus.button = 1'b0;
        guard = 0;
        while (bus.hold && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("hold_released", 32'(guard < 200), 1);
        check("in_valid_count", iv_cnt - iv0, dir ? 0 : 1);
        check("out_ack_count", ack_cnt - ack0, dir ? 1 : 0);
        if (!dir) check("captured", bus.in_data, sw);
        cyc($urandom_range(1, 5));  // phase_b and io_req still high: no re-acceptance
        bus.phase_b = 1'b0;
        bus.io_req  = 1'($urandom_range(0, 1));
        cyc($urandom_range(1, 3));
        bus.io_req  = 1'b0;
    endtask

    initial begin
        int iv0, ack0;
        bus.phase_b   = 1'b0;
        bus.io_req    = 1'b0;
        bus.io_dir    = 1'b0;
        bus.switch_in = 8'h00;
        bus.button    = 1'b0;
        cyc(3);
        check("rst_hold", bus.hold, 0);
        check("rst_waiting", bus.waiting, 0);
        check("rst_in_data", bus.in_data, 8'h00);
        check("rst_in_valid", bus.in_valid, 0);
        check("rst_out_ack", bus.out_ack, 0);
        reset = 1'b0;
        cyc(2);

        do_io(DIR_IN, 8'hA5, 1'b0, 1'b0);
        check("input_a5", bus.in_data, 8'hA5);
        do_io(DIR_OUT, 8'h3C, 1'b0, 1'b0);
        check("out_keeps_data", bus.in_data, 8'hA5);
        do_io(DIR_IN, 8'h5A, 1'b1, 1'b0);
        do_io(DIR_IN, 8'h81, 1'b0, 1'b1);

        for (int t = 0; t < 30; t++) begin
            do_io(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end

        // Reset while waiting for release.
        do_io(DIR_IN, 8'hC3, 1'b0, 1'b0);
        bus.phase_b = 1'b1;
        bus.io_req  = 1'b1;
        bus.io_dir  = DIR_OUT;
        bus.button  = 1'b1;
        cyc(D + 8);
        check("pre_reset_in_release", mode_m, 2);
        iv0  = iv_cnt;
        ack0 = ack_cnt;
        #2;
        reset      = 1'b1;
        bus.io_req = 1'b0;
        #1;
        check("midrst_hold", bus.hold, 0);
        check("midrst_waiting", bus.waiting, 0);
        check("midrst_in_data", bus.in_data, 8'h00);
        check("midrst_in_valid", bus.in_valid, 0);
        check("midrst_out_ack", bus.out_ack, 0);
        cyc(2);
        reset       = 1'b0;
        bus.button  = 1'b0;
        bus.phase_b = 1'b0;
        cyc(D + 5);
        check("midrst_no_pulses", (iv_cnt - iv0) + (ack_cnt - ack0), 0);

`ifdef IO_TIMEOUT_EN
        do_io(DIR_IN, 8'h77, 1'b0, 1'b0);
        bus.phase_b   = 1'b1;
        bus.io_req    = 1'b1;
        bus.io_dir    = DIR_IN;
        bus.switch_in = 8'hFF;
        iv0 = iv_cnt;
        cyc(TMO + 10);
        check("timeout_count", tmo_cnt, 1);
        check("timeout_in_valid", iv_cnt - iv0, 1);
        check("timeout_in_data", bus.in_data, 8'h00);
        check("timeout_hold", bus.hold, 0);
        bus.phase_b = 1'b0;
        bus.io_req  = 1'b0;
        cyc(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_pause_controller.md
# io_pause_controller

Sequences processor I/O stalls against the four-phase cycle generator (a/b/c/d). When an instruction in phase b requests input or output, the block holds the generator frozen in phase b. It waits for a debounced operator button press-and-release, captures the switch bank for input instructions, then releases the generator. It replaces the raw `button_state`/`button_pause` toggle scheme with an explicit handshake FSM.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16 — consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- TIMEOUT_CYCLES, 1000000 — wait limit in WAIT_PRESS; used only with IO_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- phase_b  in  1  phase-b level from the cycle generator.
- io_req  in  1  decoded IN/OUT instruction; valid while phase_b = 1.
- io_dir  in  1  0 = input (capture switches), 1 = output.
- switch_in  in  8  operator switch bank; treated as quasi-static.
- button  in  1  raw asynchronous operator button, active-high.
- hold  out  1  combinational stall to the cycle generator; 1 = generator must not advance.
- in_data  out  8  switch value captured on the accepted press.
- in_valid  out  1  one-cycle pulse when in_data updates (input only).
- out_ack  out  1  one-cycle pulse on completion of an output request.
- waiting  out  1  registered; 1 in WAIT_PRESS/WAIT_RELEASE (operator LED).
- timeout  out  1  one-cycle pulse on wait expiry; present only with IO_TIMEOUT_EN.

## Operation
- Button path: 2-flop synchronizer, then debouncer.
  - deb_btn changes only after DEBOUNCE_CYCLES identical consecutive synchronized samples that differ from the current deb_btn.
  - Any differing sample restarts the count.
  - Produces press (0→1) and release (1→0) single-cycle pulses.
- served flag: set on request acceptance; cleared when phase_b = 0. Ensures one acceptance per phase-b occurrence.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, RESUME.
  - IDLE: if phase_b & io_req & ~served → WAIT_PRESS; latch io_dir; set served.
  - WAIT_PRESS: press pulse → WAIT_RELEASE; if dir = input, in_data ← switch_in and in_valid pulses this same cycle.
  - WAIT_RELEASE: release pulse → RESUME.
  - RESUME: out_ack pulses if dir = output → IDLE.
- hold = (state ≠ IDLE) | (state == IDLE & phase_b & io_req & ~served). The generator therefore freezes on the same edge the request appears.
- Button activity in IDLE is debounced but ignored. A press already held at acceptance is not accepted; a fresh 0→1 transition is required.
- Reset values: state IDLE, hold 0 (given phase_b = 0 or io_req = 0), in_data 0x00, in_valid 0, out_ack 0, waiting 0, timeout 0, served 0, deb_btn 0, counters 0.
- Reset mid-wait: returns to IDLE immediately; no pulse is emitted; the captured in_data is cleared.

## Timing
- Acceptance to hold: 0 cycles (combinational).
- Minimum stall, measured from the acceptance edge to hold = 0: 2 (sync) + DEBOUNCE_CYCLES (press) + DEBOUNCE_CYCLES (release) + 1 (RESUME) cycles beyond the operator hold time.
- in_valid and out_ack are each exactly one clk wide. The generator resumes in the cycle after RESUME, i.e. phase c on the next edge.
- Simultaneous press and release pulses cannot occur; a release pulse in WAIT_PRESS is ignored.

## Configuration
- IO_TIMEOUT_EN defined:
  - A 20-bit wait counter runs in WAIT_PRESS and clears on leaving it.
  - On reaching TIMEOUT_CYCLES: go to RESUME, pulse timeout, and for input set in_data ← 0x00 with in_valid.
- Not defined: WAIT_PRESS waits indefinitely; the timeout port and counter are absent.

## Structure
- Package io_ctrl_pkg: state enum (IDLE, WAIT_PRESS, WAIT_RELEASE, RESUME), IO_DATA_W = 8, direction constants DIR_IN/DIR_OUT.
- Sub-module button_debouncer: synchronizer, counter, deb_btn, press/release pulses; parameter DEBOUNCE_CYCLES.
- Top level holds the FSM, served flag, capture register and timeout counter.

## Test plan
- Input request: phase_b = 1, io_req = 1, io_dir = 0, switch_in = 0xA5, button pulsed clean → hold rises the same cycle; in_data = 0xA5 with one in_valid pulse; hold falls 1 cycle after debounced release.
- Output request: io_dir = 1, press/release → no in_valid; one out_ack in RESUME; in_data unchanged.
- Bounce: button toggles every 3 cycles for 40 cycles with DEBOUNCE_CYCLES = 16 → no press accepted; a stable 1 for ≥ 18 cycles then accepts exactly one press.
- Re-trigger guard: phase_b kept at 1 after RESUME with io_req = 1 → no second acceptance until phase_b drops and rises again.
- Reset in WAIT_RELEASE → hold = 0 and waiting = 0 immediately; in_data = 0x00; no out_ack or in_valid.
- With IO_TIMEOUT_EN and TIMEOUT_CYCLES = 100, no button → timeout pulse at 100 cycles; in_data = 0x00; hold released one cycle later.
